// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit with HI/LO registers
// Optional build macro: MDU_FAST_MUL_EN (combinational mult/multu, no stall).
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       choice_md,
  input  logic [3:0]       choice_hilo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] rdata,
  output logic             stall,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;     // product sign for mul, quotient sign for div
  logic               r_neg_r;     // remainder follows the dividend's sign
  logic               r_div_zero;
  logic               r_done;
  logic [WIDTH-1:0]   r_x;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_a;         // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_p;         // mul: {accumulator, multiplier}; div: {remainder, quotient}

  logic               w_any_md;
  logic               w_start;
  logic               w_op_signed;
  logic               w_op_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_sub;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_p_next;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_lo_div;
  logic [WIDTH-1:0]   w_hi_div;

  // Decode the start request with mult > multu > div > divu priority.
  always_comb begin
    w_op_signed = 1'b0;
    w_op_div    = 1'b1;
    if (choice_md[0]) begin
      w_op_signed = 1'b1;
      w_op_div    = 1'b0;
    end else if (choice_md[1]) begin
      w_op_signed = 1'b0;
      w_op_div    = 1'b0;
    end else if (choice_md[2]) begin
      w_op_signed = 1'b1;
      w_op_div    = 1'b1;
    end
    w_any_md = |choice_md;
    w_a_neg  = w_op_signed & a[WIDTH-1];
    w_b_neg  = w_op_signed & b[WIDTH-1];
    w_a_mag  = w_a_neg ? -a : a;
    w_b_mag  = w_b_neg ? -b : b;
  end

`ifdef MDU_FAST_MUL_EN
  logic               w_fast_mul;
  logic [2*WIDTH-1:0] w_fast_prod;

  // Single-cycle product; sign-extending to 2*WIDTH makes the truncated product exact.
  always_comb begin
    w_fast_mul = choice_md[0] | choice_md[1];
    if (choice_md[0]) begin
      w_fast_prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      w_fast_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end
  end

  assign w_start = w_any_md & ~w_fast_mul;
`else
  assign w_start = w_any_md;
`endif

  // One shift-add or restoring-divide step, plus sign fix-up of the final result.
  always_comb begin
    w_addend    = r_p[0] ? r_x : {WIDTH{1'b0}};
    w_mul_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_div_shift = r_p[2*WIDTH-1:WIDTH-1];
    w_div_ge    = w_div_shift >= {1'b0, r_x};
    // Difference is always below the divisor when taken, so WIDTH bits suffice.
    w_div_sub   = w_div_shift[WIDTH-1:0] - r_x;
    w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
    if (r_is_div) begin
      w_p_next = {w_div_rem, r_p[WIDTH-2:0], w_div_ge};
    end else begin
      w_p_next = {w_mul_sum, r_p[WIDTH-1:1]};
    end
    w_mul_res = r_neg_q ? -w_p_next : w_p_next;
    w_quo     = w_p_next[WIDTH-1:0];
    w_rem     = w_p_next[2*WIDTH-1:WIDTH];
    w_lo_div  = r_div_zero ? {WIDTH{1'b1}} : (r_neg_q ? -w_quo : w_quo);
    w_hi_div  = r_div_zero ? r_a : (r_neg_r ? -w_rem : w_rem);
  end

  // Control FSM together with the iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_done     <= 1'b0;
      r_x        <= '0;
      r_a        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_p        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_is_div   <= w_op_div;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= w_op_div & (b == '0);
            r_a        <= a;
            r_x        <= w_op_div ? w_b_mag : w_a_mag;
            r_p        <= w_op_div ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
            r_cnt      <= '0;
            r_state    <= S_RUN;
          end
`ifdef MDU_FAST_MUL_EN
          else if (w_fast_mul) begin
            {r_hi, r_lo} <= w_fast_prod;
          end
`endif
          else begin
            if (choice_hilo[2]) r_hi <= a;
            if (choice_hilo[3]) r_lo <= a;
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            if (r_is_div) begin
              r_hi <= w_hi_div;
              r_lo <= w_lo_div;
            end else begin
              {r_hi, r_lo} <= w_mul_res;
            end
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign hi_o  = r_hi;
  assign lo_o  = r_lo;
  assign done  = r_done;
  assign stall = (r_state == S_RUN) | ((r_state == S_IDLE) & w_start);
  assign rdata = choice_hilo[0] ? r_hi : (choice_hilo[1] ? r_lo : {WIDTH{1'b0}});

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo (default build)
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  choice_md;
  logic [3:0]  choice_hilo;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] rdata;
  logic        stall;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .choice_md  (choice_md),
    .choice_hilo(choice_hilo),
    .a          (a),
    .b          (b),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .rdata      (rdata),
    .stall      (stall),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  md;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  function automatic logic [63:0] model(input logic [3:0] md, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    if (md[0]) return sx * sy;
    if (md[1]) return ux * uy;
    if (y == 32'h0) return {x, 32'hffffffff};
    if (md[2]) begin
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    q = ux / uy;
    r = ux % uy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic start_op(input logic [3:0] md, input logic [3:0] hl, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    choice_md   = md;
    choice_hilo = hl;
    a           = x;
    b           = y;
    #1;
  endtask

  // Counts stall cycles (bounded) while scrambling inputs the unit must ignore.
  task automatic finish_op(input int lat0, output logic [31:0] ohi, output logic [31:0] olo,
                           output int lat, output logic odone);
    lat = lat0;
    while (stall === 1'b1 && lat < 100) begin
      lat++;
      @(negedge clk);
      choice_md   = 4'($urandom);
      choice_hilo = 4'($urandom);
      a           = $urandom;
      b           = $urandom;
      #1;
    end
    ohi         = hi_o;
    olo         = lo_o;
    odone       = done;
    choice_md   = 4'h0;
    choice_hilo = 4'h0;
  endtask

  task automatic run_check(input string nm, input logic [3:0] md, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] ehi, input logic [31:0] elo, input bit check_after);
    logic [31:0] rhi, rlo;
    logic        rdone;
    int          lat;
    start_op(md, 4'h0, x, y);
    finish_op(0, rhi, rlo, lat, rdone);
    chk({nm, "_hi"}, {32'h0, rhi}, {32'h0, ehi});
    chk({nm, "_lo"}, {32'h0, rlo}, {32'h0, elo});
    chk({nm, "_lat"}, 64'(lat), 64'd33);
    chk({nm, "_done"}, {63'h0, rdone}, 64'd1);
    if (check_after) begin
      @(negedge clk);
      #1;
      chk({nm, "_done_clr"}, {63'h0, done}, 64'd0);
      chk({nm, "_idle_stall"}, {63'h0, stall}, 64'd0);
    end
  endtask

  initial begin
    logic [31:0] rhi, rlo, rx, ry;
    logic [3:0]  rmd;
    logic [63:0] exp;
    logic        rdone;
    int          lat;

    vecs[0]  = '{4'b0010, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001};
    vecs[1]  = '{4'b0001, 32'hfffffffd, 32'h00000005, 32'hffffffff, 32'hfffffff1};
    vecs[2]  = '{4'b0100, 32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd};
    vecs[3]  = '{4'b0100, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000};
    vecs[4]  = '{4'b1000, 32'h00000064, 32'h00000000, 32'h00000064, 32'hffffffff};
    vecs[5]  = '{4'b0100, 32'h00000007, 32'h00000000, 32'h00000007, 32'hffffffff};
    vecs[6]  = '{4'b0100, 32'hfffffff9, 32'h00000000, 32'hfffffff9, 32'hffffffff};
    vecs[7]  = '{4'b1000, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000e};
    vecs[8]  = '{4'b0001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{4'b0010, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[10] = '{4'b0100, 32'h00000007, 32'hfffffffe, 32'h00000001, 32'hfffffffd};
    vecs[11] = '{4'b0100, 32'hfffffff9, 32'hfffffffe, 32'hffffffff, 32'h00000003};
    vecs[12] = '{4'b1111, 32'hfffffffd, 32'h00000005, 32'hffffffff, 32'hfffffff1};
    vecs[13] = '{4'b1100, 32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd};

    rst = 1'b1;
    choice_md = 4'h0;
    choice_hilo = 4'h0;
    a = 32'h0;
    b = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hi", {32'h0, hi_o}, 64'h0);
    chk("reset_lo", {32'h0, lo_o}, 64'h0);
    chk("reset_stall", {63'h0, stall}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].md, vecs[i].x, vecs[i].y, vecs[i].hi, vecs[i].lo, 1'b1);
    end

    // mthi/mtlo then mfhi/mflo; same-cycle write is not forwarded.
    @(negedge clk); choice_hilo = 4'b0100; a = 32'h12345678; #1;
    chk("mthi_nostall", {63'h0, stall}, 64'h0);
    @(negedge clk); choice_hilo = 4'b0001; a = 32'h0; #1;
    chk("mfhi", {32'h0, rdata}, 64'h12345678);
    @(negedge clk); choice_hilo = 4'b1000; a = 32'haaaa5555; #1;
    @(negedge clk); choice_hilo = 4'b0010; #1;
    chk("mflo", {32'h0, rdata}, 64'haaaa5555);
    chk("mtlo_keeps_hi", {32'h0, hi_o}, 64'h12345678);
    @(negedge clk); choice_hilo = 4'b0101; a = 32'h0badf00d; #1;
    chk("mthi_no_forward", {32'h0, rdata}, 64'h12345678);
    @(negedge clk); choice_hilo = 4'b0000; #1;
    chk("rdata_zero", {32'h0, rdata}, 64'h0);
    chk("mthi_written", {32'h0, hi_o}, 64'h0badf00d);

    // mtlo together with divu: divu wins, mtlo dropped; mthi in RUN ignored.
    start_op(4'b1000, 4'b1000, 32'h00000055, 32'h00000003);
    chk("md_hilo_stall", {63'h0, stall}, 64'h1);
    @(negedge clk); choice_md = 4'b0001; choice_hilo = 4'b0100; a = 32'hdeadbeef; b = 32'h1; #1;
    chk("mtlo_dropped", {32'h0, lo_o}, 64'haaaa5555);
    finish_op(1, rhi, rlo, lat, rdone);
    chk("md_hilo_hi", {32'h0, rhi}, 64'h1);
    chk("md_hilo_lo", {32'h0, rlo}, 64'h1c);
    chk("md_hilo_lat", 64'(lat), 64'd33);

    // Reset in RUN cycle 10 aborts; a following mult completes normally.
    start_op(4'b1000, 4'h0, 32'h00000064, 32'h00000007);
    repeat (10) begin @(negedge clk); choice_md = 4'h0; end
    #1;
    chk("run10_stall", {63'h0, stall}, 64'h1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("abort_stall", {63'h0, stall}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    chk("abort_hi", {32'h0, hi_o}, 64'h0);
    chk("abort_lo", {32'h0, lo_o}, 64'h0);
    run_check("after_abort", 4'b0001, 32'hfffffffd, 32'h00000005, 32'hffffffff, 32'hfffffff1, 1'b1);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rmd = 4'b0001 << $urandom_range(0, 3);
      rx  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'h0;
        1:       ry = $urandom_range(1, 15);
        2:       ry = 32'hffffffff;
        default: ry = $urandom;
      endcase
      exp = model(rmd, rx, ry);
      run_check($sformatf("rand%0d_md%0h", i, rmd), rmd, rx, ry, exp[63:32], exp[31:0], 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
